// File: rtl/fc_spi_pkg.sv
// Shared framing definitions for the frequency counter SPI link.
// Both the host-side master and the counter's slave import this package so the
// command word layout cannot drift between the two ends.
package fc_spi_pkg;

   // Command word layout: [15] wr, [14:12] zero, [11:8] addr, [7:0] data
   localparam int FRAME_BITS = 16;
   localparam int WR_BIT     = 15;
   localparam int ADDR_LSB   = 8;
   localparam int DATA_LSB   = 0;
   localparam int ADDR_BITS  = 4;
   localparam int DATA_BITS  = 8;

   // Bit counter spans 0..FRAME_BITS inclusive, so it needs one bit more than the index
   localparam int BIT_CNT_W = 5;
   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      LEAD,
      SHIFT,
      LAG,
      GAP
   } spi_state_t;

   // Reads carry zero in the data field; the slave returns the register there.
   function automatic logic [FRAME_BITS-1:0] build_cmd(
      input logic                 wr,
      input logic [ADDR_BITS-1:0] addr,
      input logic [DATA_BITS-1:0] data
   );
      logic [FRAME_BITS-1:0] w;
      w = '0;
      w[WR_BIT] = wr;
      w[ADDR_LSB +: ADDR_BITS] = addr;
      if (wr) begin
         w[DATA_LSB +: DATA_BITS] = data;
      end
      return w;
   endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator for the SPI master.
// A down-counter is held at CLK_DIV-1 while disabled and reloaded on every
// tick, so each enabled phase lasts exactly CLK_DIV cycles. While shift_en is
// high a phase bit tracks which half of the bit period is running and turns
// ticks into rise/fall strobes for spi_clk.
module spi_clk_div
   import fc_spi_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic shift_en,
   output logic tick,
   output logic rise,
   output logic fall
);

   localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;
   logic          phase;

   assign tick = en && (cnt == '0);
   assign rise = tick && shift_en && !phase;
   assign fall = tick && shift_en && phase;

   // Count down through each half-period; reload at its end or while idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (!en || tick) begin
         cnt <= RELOAD;
      end else begin
         cnt <= cnt - 1'b1;
      end
   end

   // Track low/high half of the bit period; starts low at the first shift phase
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase <= 1'b0;
      end else if (!shift_en) begin
         phase <= 1'b0;
      end else if (tick) begin
         phase <= ~phase;
      end
   end

endmodule

// File: rtl/spi_master.sv
// Host-side SPI initiator for the frequency counter register interface.
// One 16-bit transaction per accepted start: command byte then data byte,
// mode 0, MSB first. The frame is ss_n-low lead, 16 bit periods, lag, and a
// ss_n-high gap; done pulses on the cycle the FSM returns to IDLE.
module spi_master
   import fc_spi_pkg::*;
#(
   parameter int CLK_DIV    = 4,
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  wr,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  spi_clk,
   output logic                  spi_mosi,
   input  logic                  spi_miso,
   output logic                  spi_ss_n
);

   spi_state_t state, state_nxt;

   logic                  div_en;
   logic                  shift_en;
   logic                  tick;
   logic                  rise;
   logic                  fall;
   logic                  accept;
   logic                  finish;
   logic                  lag_end;
   logic [FRAME_BITS-1:0] frame;
   logic [FRAME_BITS-1:0] tx_sr;
   logic [DATA_WIDTH-1:0] rx_sr;
   logic [BIT_CNT_W-1:0]  bit_cnt;
   logic                  wr_q;

   assign frame    = build_cmd(wr, addr, wdata);
   assign busy     = (state != IDLE);
   assign div_en   = (state != IDLE);
   assign shift_en = (state == SHIFT);

   spi_clk_div #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_div (
      .clk      (clk),
      .rst      (rst),
      .en       (div_en),
      .shift_en (shift_en),
      .tick     (tick),
      .rise     (rise),
      .fall     (fall)
   );

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and transaction boundary strobes
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      finish    = 1'b0;
      lag_end   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = LEAD;
            end
         end
         LEAD: begin
            if (tick) begin
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (fall && (bit_cnt == LAST_BIT)) begin
               state_nxt = LAG;
            end
         end
         LAG: begin
            if (tick) begin
               lag_end   = 1'b1;
               state_nxt = GAP;
            end
         end
         GAP: begin
            if (tick) begin
               finish    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Serial pins: select, clock and MOSI, all registered so they are glitch-free
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         spi_ss_n <= 1'b1;
         spi_clk  <= 1'b0;
         spi_mosi <= 1'b0;
         tx_sr    <= '0;
      end else begin
         if (accept) begin
            spi_ss_n <= 1'b0;
         end else if (lag_end) begin
            spi_ss_n <= 1'b1;
         end

         if (rise) begin
            spi_clk <= 1'b1;
         end else if (fall) begin
            spi_clk <= 1'b0;
         end

         // The shifter fills with zeros, so MOSI lands at 0 after the last bit
         if (accept) begin
            spi_mosi <= frame[FRAME_BITS-1];
            tx_sr    <= {frame[FRAME_BITS-2:0], 1'b0};
         end else if (fall) begin
            spi_mosi <= tx_sr[FRAME_BITS-1];
            tx_sr    <= {tx_sr[FRAME_BITS-2:0], 1'b0};
         end
      end
   end

   // Receive path and bit counting; only the last DATA_WIDTH MISO bits are kept
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_sr   <= '0;
         bit_cnt <= '0;
         wr_q    <= 1'b0;
      end else begin
         if (accept) begin
            rx_sr   <= '0;
            bit_cnt <= '0;
            wr_q    <= wr;
         end else begin
            if (rise) begin
               rx_sr <= {rx_sr[DATA_WIDTH-2:0], spi_miso};
            end
            if (fall) begin
               bit_cnt <= bit_cnt + 1'b1;
            end
         end
      end
   end

   // Completion: one-cycle done and read data capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done  <= 1'b0;
         rdata <= '0;
      end else begin
         done <= finish;
         if (finish && !wr_q) begin
            rdata <= rx_sr;
         end
      end
   end

endmodule
